// File: rtl/processing_element_os_pipe.sv
// Output-stationary systolic PE: forwards A east / B south, multiply-accumulates valid pairs
// through a configurable product pipeline and drains tile results north on a shift chain.
module processing_element_os_pipe #(
  parameter int WIDTH_A    = 16,
  parameter int WIDTH_B    = 16,
  parameter int WIDTH_ACC  = 40,
  parameter int MUL_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 signed_mode,
  input  logic                 sat_en,
  input  logic [WIDTH_A-1:0]   a_in,
  input  logic                 a_valid_in,
  input  logic [WIDTH_B-1:0]   b_in,
  input  logic                 b_valid_in,
  input  logic                 first_in,
  input  logic                 last_in,
  output logic [WIDTH_A-1:0]   a_out,
  output logic                 a_valid_out,
  output logic                 first_out,
  output logic                 last_out,
  output logic [WIDTH_B-1:0]   b_out,
  output logic                 b_valid_out,
  input  logic                 shift_en,
  input  logic [WIDTH_ACC-1:0] res_in,
  output logic [WIDTH_ACC-1:0] res_out,
  output logic                 res_valid,
  output logic                 ovf
);

  localparam int WP  = WIDTH_A + WIDTH_B;
  // Pipeline word: {valid, first, last, signed_mode, sat_en, extended product}
  localparam int LEN = WIDTH_ACC + 5;

  logic fire;
  assign fire = a_valid_in & b_valid_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      first_out   <= 1'b0;
      last_out    <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else if (!stall) begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      first_out   <= first_in;
      last_out    <= last_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Operand capture stage; tags are masked so non-fire cycles become bubbles.
  logic [WIDTH_A-1:0] op_a;
  logic [WIDTH_B-1:0] op_b;
  logic               op_v, op_first, op_last, op_signed, op_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      op_v      <= 1'b0;
      op_first  <= 1'b0;
      op_last   <= 1'b0;
      op_signed <= 1'b0;
      op_sat    <= 1'b0;
    end else if (!stall) begin
      op_a      <= a_in;
      op_b      <= b_in;
      op_v      <= fire;
      op_first  <= fire & first_in;
      op_last   <= fire & last_in;
      op_signed <= signed_mode;
      op_sat    <= sat_en;
    end
  end

  logic [WP-1:0]        ext_a, ext_b, prod;
  logic signed [WP-1:0] prod_s;
  logic [WIDTH_ACC-1:0] p_ext;
  logic [LEN-1:0]       s0;

  always_comb begin
    if (op_signed) begin
      ext_a = {{WIDTH_B{op_a[WIDTH_A-1]}}, op_a};
      ext_b = {{WIDTH_A{op_b[WIDTH_B-1]}}, op_b};
    end else begin
      ext_a = {{WIDTH_B{1'b0}}, op_a};
      ext_b = {{WIDTH_A{1'b0}}, op_b};
    end
    prod   = ext_a * ext_b;
    prod_s = $signed(prod);
    if (op_signed) p_ext = WIDTH_ACC'(prod_s);
    else           p_ext = WIDTH_ACC'(prod);
    s0 = {op_v, op_first, op_last, op_signed, op_sat, p_ext};
  end

  logic [LEN-1:0] acc_in;

  generate
    if (MUL_STAGES == 0) begin : g_comb
      assign acc_in = s0;
    end else begin : g_pipe
      logic [LEN-1:0] q [MUL_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MUL_STAGES; i++) q[i] <= '0;
        end else if (!stall) begin
          q[0] <= s0;
          for (int i = 1; i < MUL_STAGES; i++) q[i] <= q[i-1];
        end
      end
      assign acc_in = q[MUL_STAGES-1];
    end
  endgenerate

  logic                 in_v, in_first, in_last, in_signed, in_sat;
  logic [WIDTH_ACC-1:0] in_p;
  logic [WIDTH_ACC-1:0] acc, acc_next, sat_val;
  logic [WIDTH_ACC:0]   sum;
  logic                 ovf_now, ovf_next, cap_pend;

  always_comb begin
    in_v      = acc_in[LEN-1];
    in_first  = acc_in[LEN-2];
    in_last   = acc_in[LEN-3];
    in_signed = acc_in[LEN-4];
    in_sat    = acc_in[LEN-5];
    in_p      = acc_in[WIDTH_ACC-1:0];
    if (in_signed) begin
      sum     = {acc[WIDTH_ACC-1], acc} + {in_p[WIDTH_ACC-1], in_p};
      ovf_now = sum[WIDTH_ACC] ^ sum[WIDTH_ACC-1];
      // The extra sum bit is the true sign, so it picks the clamp direction.
      sat_val = sum[WIDTH_ACC] ? {1'b1, {(WIDTH_ACC-1){1'b0}}} : {1'b0, {(WIDTH_ACC-1){1'b1}}};
    end else begin
      sum     = {1'b0, acc} + {1'b0, in_p};
      ovf_now = sum[WIDTH_ACC];
      sat_val = '1;
    end
    if (in_first) begin
      acc_next = in_p;
      ovf_next = 1'b0;
    end else begin
      acc_next = (ovf_now && in_sat) ? sat_val : sum[WIDTH_ACC-1:0];
      ovf_next = ovf | ovf_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      ovf      <= 1'b0;
      cap_pend <= 1'b0;
    end else if (!stall) begin
      if (in_v) begin
        acc      <= acc_next;
        ovf      <= ovf_next;
        cap_pend <= in_last;
      end else begin
        cap_pend <= 1'b0;
      end
    end
  end

  // A pending capture beats a shift; res_in is dropped on that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_out   <= '0;
      res_valid <= 1'b0;
    end else if (!stall) begin
      if (cap_pend) begin
        res_out   <= acc;
        res_valid <= 1'b1;
      end else if (shift_en) begin
        res_out   <= res_in;
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_processing_element_os_pipe.sv
// Bench for processing_element_os_pipe: a 40-bit and a 32-bit accumulator instance share
// stimulus and are checked against an arithmetic reference model of the tile results.
module tb_processing_element_os_pipe;

  localparam int MS = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, signed_mode, sat_en, shift_en;
  logic [15:0] a_in, b_in;
  logic        a_valid_in, b_valid_in, first_in, last_in;
  logic [39:0] res_in;

  logic [15:0] a_out, b_out, a_out_n, b_out_n;
  logic        a_valid_out, first_out, last_out, b_valid_out;
  logic        a_valid_out_n, first_out_n, last_out_n, b_valid_out_n;
  logic [39:0] res_out;
  logic [31:0] res_out_n;
  logic        res_valid, ovf, res_valid_n, ovf_n;

  processing_element_os_pipe #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_ACC(40), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst(rst), .stall(stall), .signed_mode(signed_mode), .sat_en(sat_en),
    .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .first_in(first_in), .last_in(last_in),
    .a_out(a_out), .a_valid_out(a_valid_out), .first_out(first_out), .last_out(last_out),
    .b_out(b_out), .b_valid_out(b_valid_out),
    .shift_en(shift_en), .res_in(res_in), .res_out(res_out), .res_valid(res_valid), .ovf(ovf)
  );

  processing_element_os_pipe #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_ACC(32), .MUL_STAGES(MS)) dut_n (
    .clk(clk), .rst(rst), .stall(stall), .signed_mode(signed_mode), .sat_en(sat_en),
    .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .first_in(first_in), .last_in(last_in),
    .a_out(a_out_n), .a_valid_out(a_valid_out_n), .first_out(first_out_n), .last_out(last_out_n),
    .b_out(b_out_n), .b_valid_out(b_valid_out_n),
    .shift_en(shift_en), .res_in(res_in[31:0]), .res_out(res_out_n), .res_valid(res_valid_n),
    .ovf(ovf_n)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state and expected outputs
  int          cyc;
  logic [63:0] m_acc0, m_acc1;
  bit          m_ovf0, m_ovf1;
  logic [15:0] e_a, e_b;
  logic        e_av, e_bv, e_first, e_last, e_rv;
  logic [39:0] e_res0;
  logic [31:0] e_res1;
  logic        e_ovf0, e_ovf1;
  logic [63:0] cap0_ev [int];
  logic [63:0] cap1_ev [int];
  bit          ovf0_ev [int];
  bit          ovf1_ev [int];

  // One multiply-accumulate on a w-bit accumulator, done in plain integer arithmetic.
  function automatic void mac(input int w, input bit sm, input bit sat, input bit first,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [63:0] acc_i, input bit ovf_i,
                              output logic [63:0] acc_o, output bit ovf_o);
    longint pa, pb, p, cur, sum, maxv, minv, span;
    span = longint'(1) << w;
    if (sm) begin
      pa   = longint'($signed(a));
      pb   = longint'($signed(b));
      maxv = span / 2 - 1;
      minv = -(span / 2);
      cur  = acc_i[w-1] ? longint'(acc_i) - span : longint'(acc_i);
    end else begin
      pa   = longint'(a);
      pb   = longint'(b);
      maxv = span - 1;
      minv = 0;
      cur  = longint'(acc_i);
    end
    p     = pa * pb;
    ovf_o = ovf_i;
    if (first) begin
      sum   = p;
      ovf_o = 1'b0;
    end else begin
      sum = cur + p;
      if (sum > maxv || sum < minv) begin
        ovf_o = 1'b1;
        if (sat) sum = (sum > maxv) ? maxv : minv;
      end
    end
    acc_o = 64'(sum) & 64'(span - 1);
  endfunction

  // Advance one clock edge and update the model with the inputs sampled there.
  task automatic tick();
    logic [63:0] na0, na1, t0, t1;
    bit          no0, no1;
    @(posedge clk);
    if (rst) begin
      {e_a, e_av, e_first, e_last, e_b, e_bv} = '0;
      e_res0 = '0; e_res1 = '0; e_rv = 1'b0; e_ovf0 = 1'b0; e_ovf1 = 1'b0;
      m_acc0 = '0; m_acc1 = '0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
      cap0_ev.delete(); cap1_ev.delete(); ovf0_ev.delete(); ovf1_ev.delete();
      cyc = 0;
    end else if (!stall) begin
      cyc++;
      e_a = a_in; e_av = a_valid_in; e_first = first_in; e_last = last_in;
      e_b = b_in; e_bv = b_valid_in;
      if (ovf0_ev.exists(cyc)) begin
        e_ovf0 = ovf0_ev[cyc]; e_ovf1 = ovf1_ev[cyc];
        ovf0_ev.delete(cyc); ovf1_ev.delete(cyc);
      end
      if (cap0_ev.exists(cyc)) begin
        t0 = cap0_ev[cyc]; t1 = cap1_ev[cyc];
        e_res0 = t0[39:0]; e_res1 = t1[31:0]; e_rv = 1'b1;
        cap0_ev.delete(cyc); cap1_ev.delete(cyc);
      end else if (shift_en) begin
        e_res0 = res_in; e_res1 = res_in[31:0]; e_rv = 1'b0;
      end
      if (a_valid_in && b_valid_in) begin
        mac(40, signed_mode, sat_en, first_in, a_in, b_in, m_acc0, m_ovf0, na0, no0);
        mac(32, signed_mode, sat_en, first_in, a_in, b_in, m_acc1, m_ovf1, na1, no1);
        m_acc0 = na0; m_ovf0 = no0; m_acc1 = na1; m_ovf1 = no1;
        ovf0_ev[cyc+MS+1] = m_ovf0;
        ovf1_ev[cyc+MS+1] = m_ovf1;
        if (last_in) begin
          cap0_ev[cyc+MS+2] = m_acc0;
          cap1_ev[cyc+MS+2] = m_acc1;
        end
      end
    end
    #1;
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] b, input bit f, input bit l);
    a_in = a; b_in = b; a_valid_in = 1'b1; b_valid_in = 1'b1; first_in = f; last_in = l;
    tick();
  endtask

  task automatic idle(input int n);
    a_valid_in = 1'b0; b_valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_drain();
    shift_en = 1'b1; res_in = '0;
    idle(1);
    shift_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    vectors++;
    if ({a_out, a_valid_out, first_out, last_out, b_out, b_valid_out, res_out, res_valid, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_wide: got a=%h b=%h res=%h rv=%b ovf=%b want all 0", a_out, b_out, res_out, res_valid, ovf);
    end
    vectors++;
    if ({a_out_n, b_out_n, res_out_n, res_valid_n, ovf_n} !== '0) begin
      miscompares++;
      $display("FAIL reset_narrow: got res=%h rv=%b ovf=%b want all 0", res_out_n, res_valid_n, ovf_n);
    end
    rst = 1'b0;
    signed_mode = 1'b0; sat_en = 1'b0;
    put(16'd9, 16'd9, 1'b1, 1'b0);
    put(16'd9, 16'd9, 1'b0, 1'b0);
    rst = 1'b1;
    put(16'd10, 16'd10, 1'b0, 1'b1);
    vectors++;
    if ({a_out, a_valid_out, last_out, b_out, b_valid_out, res_out, res_valid, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_midtile: got a=%h av=%b res=%h rv=%b want all 0", a_out, a_valid_out, res_out, res_valid);
    end
    rst = 1'b0;
    put(16'd2, 16'd3, 1'b1, 1'b0);
    put(16'd4, 16'd5, 1'b0, 1'b1);
    idle(MS + 2);
    vectors++;
    if ({res_out, res_valid, ovf} !== {40'd26, 1'b1, 1'b0} || res_out !== e_res0) begin
      miscompares++;
      $display("FAIL reset_after_tile: got res=%0d rv=%b ovf=%b want 26 1 0", res_out, res_valid, ovf);
    end
  endtask

  task automatic test_unsigned_dot();
    signed_mode = 1'b0; sat_en = 1'b0;
    clear_drain();
    put(16'd1, 16'd5, 1'b1, 1'b0);
    put(16'd2, 16'd6, 1'b0, 1'b0);
    put(16'd3, 16'd7, 1'b0, 1'b0);
    put(16'd4, 16'd8, 1'b0, 1'b1);
    idle(MS + 1);
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dot_early: got rv=%b want 0 one cycle before capture", res_valid);
    end
    idle(1);
    vectors++;
    if ({res_out, res_valid, ovf} !== {40'd70, 1'b1, 1'b0} || res_out !== e_res0) begin
      miscompares++;
      $display("FAIL dot_result: got res=%0d rv=%b ovf=%b want 70 1 0", res_out, res_valid, ovf);
    end
  endtask

  task automatic test_signed_single();
    signed_mode = 1'b1; sat_en = 1'b0;
    put(16'hFFFD, 16'd7, 1'b1, 1'b1);
    idle(MS + 2);
    vectors++;
    if ({res_out, res_valid, ovf} !== {40'hFF_FFFF_FFEB, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL signed_single_wide: got res=%h rv=%b ovf=%b want ffffffffeb 1 0", res_out, res_valid, ovf);
    end
    vectors++;
    if (res_out_n !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("FAIL signed_single_narrow: got res=%h want ffffffeb", res_out_n);
    end
  endtask

  task automatic test_sat_wrap();
    logic [31:0] wrapped;
    wrapped = 32'(3 * 32767 * 32767);
    signed_mode = 1'b1;
    for (int s = 1; s >= 0; s--) begin
      sat_en = s[0];
      put(16'd32767, 16'd32767, 1'b1, 1'b0);
      put(16'd32767, 16'd32767, 1'b0, 1'b0);
      put(16'd32767, 16'd32767, 1'b0, 1'b1);
      idle(MS + 2);
      vectors++;
      if ({res_out_n, ovf_n} !== {(s == 1) ? 32'h7FFF_FFFF : wrapped, 1'b1} || res_out_n !== e_res1) begin
        miscompares++;
        $display("FAIL sat_wrap_narrow sat=%0d: got res=%h ovf=%b want %h 1", s, res_out_n, ovf_n,
                 (s == 1) ? 32'h7FFF_FFFF : wrapped);
      end
      vectors++;
      if ({res_out, ovf} !== {40'h00_BFFD_0003, 1'b0}) begin
        miscompares++;
        $display("FAIL sat_wrap_wide sat=%0d: got res=%h ovf=%b want 00bffd0003 0", s, res_out, ovf);
      end
    end
    sat_en = 1'b0;
  endtask

  task automatic test_stall_drain();
    signed_mode = 1'b0; sat_en = 1'b0;
    clear_drain();
    put(16'd3, 16'd4, 1'b1, 1'b0);
    put(16'd5, 16'd6, 1'b0, 1'b0);
    stall = 1'b1;
    put(16'd99, 16'd99, 1'b1, 1'b1);
    put(16'd98, 16'd98, 1'b0, 1'b0);
    put(16'd97, 16'd97, 1'b1, 1'b0);
    vectors++;
    if ({a_out, b_out} !== {16'd5, 16'd6}) begin
      miscompares++;
      $display("FAIL stall_hold: got a=%0d b=%0d want 5 6", a_out, b_out);
    end
    stall = 1'b0;
    put(16'd7, 16'd8, 1'b0, 1'b1);
    idle(1);
    stall = 1'b1;
    idle(3);
    stall = 1'b0;
    idle(MS);
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_early: got rv=%b want 0", res_valid);
    end
    idle(1);
    vectors++;
    if ({res_out, res_valid} !== {40'd98, 1'b1}) begin
      miscompares++;
      $display("FAIL stall_result: got res=%0d rv=%b want 98 1", res_out, res_valid);
    end
    shift_en = 1'b1; res_in = 40'h123;
    idle(1);
    shift_en = 1'b0;
    vectors++;
    if ({res_out, res_valid} !== {40'h123, 1'b0}) begin
      miscompares++;
      $display("FAIL drain_shift: got res=%h rv=%b want 123 0", res_out, res_valid);
    end
    put(16'd6, 16'd7, 1'b1, 1'b1);
    idle(MS + 1);
    shift_en = 1'b1; res_in = 40'h456;
    idle(1);
    shift_en = 1'b0;
    vectors++;
    if ({res_out, res_valid} !== {40'd42, 1'b1}) begin
      miscompares++;
      $display("FAIL capture_vs_shift: got res=%h rv=%b want 2a 1", res_out, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    signed_mode = 1'b0; sat_en = 1'b0;
    put(16'd2, 16'd3, 1'b1, 1'b1);
    put(16'd4, 16'd5, 1'b1, 1'b0);
    put(16'd1, 16'd1, 1'b0, 1'b1);
    idle(MS);
    vectors++;
    if ({res_out, res_valid} !== {40'd6, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_first: got res=%0d rv=%b want 6 1", res_out, res_valid);
    end
    idle(2);
    vectors++;
    if ({res_out, res_valid} !== {40'd21, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_second: got res=%0d rv=%b want 21 1", res_out, res_valid);
    end
  endtask

  task automatic test_random();
    int  tile_len, tile_idx;
    bit  fire;
    tile_len = 1; tile_idx = 0;
    for (int n = 0; n < 1100; n++) begin
      if (n < 1000) begin
        stall      = ($urandom_range(0, 19) == 0);
        a_valid_in = ($urandom_range(0, 9) < 8);
        b_valid_in = ($urandom_range(0, 9) < 8);
        a_in       = 16'($urandom_range(0, 65535));
        b_in       = 16'($urandom_range(0, 65535));
        shift_en   = ($urandom_range(0, 9) < 3);
        res_in     = {8'($urandom_range(0, 255)), 32'($urandom)};
        if ($urandom_range(0, 9) == 0) signed_mode = ~signed_mode;
        if ($urandom_range(0, 9) == 0) sat_en = ~sat_en;
        fire = a_valid_in && b_valid_in && !stall;
        if (fire) begin
          if (tile_idx == 0) tile_len = $urandom_range(1, 6);
          first_in = (tile_idx == 0);
          last_in  = (tile_idx == tile_len - 1);
          tile_idx = last_in ? 0 : tile_idx + 1;
        end else begin
          first_in = 1'($urandom_range(0, 1));
          last_in  = 1'($urandom_range(0, 1));
        end
      end else begin
        stall = 1'b0; a_valid_in = 1'b0; b_valid_in = 1'b0; shift_en = 1'b0;
      end
      tick();
      vectors++;
      if ({a_out, a_valid_out, first_out, last_out, b_out, b_valid_out} !== {e_a, e_av, e_first, e_last, e_b, e_bv} ||
          {a_out_n, a_valid_out_n, first_out_n, last_out_n, b_out_n, b_valid_out_n} !== {e_a, e_av, e_first, e_last, e_b, e_bv}) begin
        miscompares++;
        $display("FAIL rand_fwd cyc %0d: got a=%h av=%b f=%b l=%b b=%h bv=%b want a=%h av=%b f=%b l=%b b=%h bv=%b",
                 n, a_out, a_valid_out, first_out, last_out, b_out, b_valid_out, e_a, e_av, e_first, e_last, e_b, e_bv);
      end
      vectors++;
      if ({res_out, res_valid, ovf} !== {e_res0, e_rv, e_ovf0}) begin
        miscompares++;
        $display("FAIL rand_wide cyc %0d: got res=%h rv=%b ovf=%b want res=%h rv=%b ovf=%b",
                 n, res_out, res_valid, ovf, e_res0, e_rv, e_ovf0);
      end
      vectors++;
      if ({res_out_n, res_valid_n, ovf_n} !== {e_res1, e_rv, e_ovf1}) begin
        miscompares++;
        $display("FAIL rand_narrow cyc %0d: got res=%h rv=%b ovf=%b want res=%h rv=%b ovf=%b",
                 n, res_out_n, res_valid_n, ovf_n, e_res1, e_rv, e_ovf1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; signed_mode = 1'b0; sat_en = 1'b0; shift_en = 1'b0;
    a_in = '0; b_in = '0; a_valid_in = 1'b0; b_valid_in = 1'b0;
    first_in = 1'b0; last_in = 1'b0; res_in = '0;
    test_reset();
    test_unsigned_dot();
    test_signed_single();
    test_sat_wrap();
    test_stall_drain();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
